jtag_seq: RTL

Command sequencer in front of the `jtag` shift engine.
- Arbitrates two requesters, round-robin.
- Per command it issues an IR scan (op=0), then a DR scan (op=1), by driving the engine's work/op/len/rdata_instraction/rdata_data.
- Paces each phase with an internal cycle counter, then acks the requester.
- Sits between host-side command sources and the `jtag` engine; the engine's tdo input is shared with this block.

---
 rtl/jtag_seq.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | jtag_seq : round-robin command sequencer issuing IR then DR scans to `jtag` |
// | Option macro: JTAG_SEQ_TDO_CAPTURE_EN (DR read-back into rdo)   Rev 1.0     |
// +-----------------------------------------------------------------------------+
module jtag_seq #(
    parameter int PRE_OVH  = 4,
    parameter int POST_OVH = 2,
    parameter int IR_MAX   = 10,
    parameter int DR_MAX   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic [IR_MAX-1:0]   ir0,
    input  logic [DR_MAX-1:0]   dr0,
    input  logic [3:0]          irlen0,
    input  logic [3:0]          drlen0,
    output logic                ack0,
    input  logic                req1,
    input  logic [IR_MAX-1:0]   ir1,
    input  logic [DR_MAX-1:0]   dr1,
    input  logic [3:0]          irlen1,
    input  logic [3:0]          drlen1,
    output logic                ack1,
    output logic                work,
    output logic                op,
    output logic [15:0]         len,
    output logic [IR_MAX-1:0]   rdata_instraction,
    output logic [DR_MAX-1:0]   rdata_data,
    input  logic                tdo,
    output logic                busy,
    output logic                grant_id,
    output logic [DR_MAX-1:0]   rdo
);

    localparam int LMAX = (IR_MAX > DR_MAX) ? IR_MAX : DR_MAX;
    localparam int WMAX = PRE_OVH + LMAX + POST_OVH;
    localparam int CW   = $clog2(WMAX + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] IR_GO   = 3'd1;
    localparam logic [2:0] IR_WAIT = 3'd2;
    localparam logic [2:0] DR_GO   = 3'd3;
    localparam logic [2:0] DR_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [3:0] IR_MAX_L = 4'(IR_MAX);
    localparam logic [3:0] DR_MAX_L = 4'(DR_MAX);

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               gid_q, gid_d;
    logic [IR_MAX-1:0]  irv_q, irv_d;
    logic [DR_MAX-1:0]  drv_q, drv_d;
    logic [3:0]         irl_q, irl_d;
    logic [3:0]         drl_q, drl_d;
    logic               work_q, work_d;
    logic               op_q, op_d;
    logic [15:0]        len_q, len_d;
    logic [IR_MAX-1:0]  rir_q, rir_d;
    logic [DR_MAX-1:0]  rdr_q, rdr_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               busy_q, busy_d;

    // Requester selection: on contention the one not served last time wins
    logic               w_any;
    logic               w_pick1;
    logic [IR_MAX-1:0]  w_ir;
    logic [DR_MAX-1:0]  w_dr;
    logic [3:0]         w_irl_raw;
    logic [3:0]         w_drl_raw;
    logic [3:0]         w_irl;
    logic [3:0]         w_drl;
    logic [CW-1:0]      w_ir_last;
    logic [CW-1:0]      w_dr_last;

    assign w_any     = req0 | req1;
    assign w_pick1   = (req0 && req1) ? ~last_q : req1;
    assign w_ir      = w_pick1 ? ir1    : ir0;
    assign w_dr      = w_pick1 ? dr1    : dr0;
    assign w_irl_raw = w_pick1 ? irlen1 : irlen0;
    assign w_drl_raw = w_pick1 ? drlen1 : drlen0;
    assign w_irl     = (w_irl_raw > IR_MAX_L) ? IR_MAX_L : w_irl_raw;
    assign w_drl     = (w_drl_raw > DR_MAX_L) ? DR_MAX_L : w_drl_raw;

    // Final counter value of each wait phase (phase lasts PRE+len+POST cycles)
    assign w_ir_last = CW'(PRE_OVH + POST_OVH - 1) + CW'(irl_q);
    assign w_dr_last = CW'(PRE_OVH + POST_OVH - 1) + CW'(drl_q);

`ifdef JTAG_SEQ_TDO_CAPTURE_EN
    logic [DR_MAX-1:0]  rdo_q, rdo_d;
`else
    logic               w_unused_tdo;
    assign w_unused_tdo = tdo;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gid_d   = gid_q;
        irv_d   = irv_q;
        drv_d   = drv_q;
        irl_d   = irl_q;
        drl_d   = drl_q;
        work_d  = 1'b0;
        op_d    = op_q;
        len_d   = len_q;
        rir_d   = rir_q;
        rdr_d   = rdr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b1;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
        rdo_d   = rdo_q;
`endif

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    last_d = w_pick1;
                    gid_d  = w_pick1;
                    irv_d  = w_ir;
                    drv_d  = w_dr;
                    irl_d  = w_irl;
                    drl_d  = w_drl;
                    if (w_irl != 4'd0)      state_d = IR_GO;
                    else if (w_drl != 4'd0) state_d = DR_GO;
                    else                    state_d = DONE;
                end
            end
            IR_GO: begin
                cnt_d   = '0;
                state_d = IR_WAIT;
            end
            IR_WAIT: begin
                if (cnt_q == w_ir_last) state_d = (drl_q != 4'd0) ? DR_GO : DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            DR_GO: begin
                cnt_d   = '0;
                state_d = DR_WAIT;
            end
            DR_WAIT: begin
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
                for (int i = 0; i < DR_MAX; i++) begin
                    if ((i < int'(drl_q)) && (cnt_q == CW'(PRE_OVH + i))) rdo_d[i] = tdo;
                end
`endif
                if (cnt_q == w_dr_last) state_d = DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered so they line up with the state being entered
        case (state_d)
            IDLE:  busy_d = 1'b0;
            IR_GO: begin
                work_d = 1'b1;
                op_d   = 1'b0;
                len_d  = 16'(irl_d);
                rir_d  = irv_d;
            end
            DR_GO: begin
                work_d = 1'b1;
                op_d   = 1'b1;
                len_d  = 16'(drl_d);
                rdr_d  = drv_d;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
                rdo_d  = '0;
`endif
            end
            DONE: begin
                ack0_d = ~gid_d;
                ack1_d = gid_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
            irv_q   <= '0;
            drv_q   <= '0;
            irl_q   <= '0;
            drl_q   <= '0;
            work_q  <= 1'b0;
            op_q    <= 1'b0;
            len_q   <= '0;
            rir_q   <= '0;
            rdr_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
            rdo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            irv_q   <= irv_d;
            drv_q   <= drv_d;
            irl_q   <= irl_d;
            drl_q   <= drl_d;
            work_q  <= work_d;
            op_q    <= op_d;
            len_q   <= len_d;
            rir_q   <= rir_d;
            rdr_q   <= rdr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
            rdo_q   <= rdo_d;
`endif
        end
    end

    assign ack0              = ack0_q;
    assign ack1              = ack1_q;
    assign work              = work_q;
    assign op                = op_q;
    assign len               = len_q;
    assign rdata_instraction = rir_q;
    assign rdata_data        = rdr_q;
    assign busy              = busy_q;
    assign grant_id          = gid_q;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
    assign rdo               = rdo_q;
`else
    assign rdo               = '0;
`endif

endmodule
`default_nettype wire
